// File: rtl/rr_sel_pkg.sv
// ---------------------------------------------------------------------------
// rr_sel_pkg -- shared definitions for the round-robin mux-select arbiter.
//   NCH     : number of requesting channels (downstream 4:1 mux inputs)
//   SEL_W   : width of a channel index
//   state_t : arbiter state (IDLE: no grant held, GRANT: sel holds a grant)
// ---------------------------------------------------------------------------
package rr_sel_pkg;

    localparam int NCH   = 4;
    localparam int SEL_W = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

endpackage : rr_sel_pkg

// File: rtl/rr_sel_arb_if.sv
// ---------------------------------------------------------------------------
// rr_sel_arb_if -- request / select handshake between requesters, the
// arbiter and the downstream 4:1 mux.
//   req     : per-channel request (bit i requests din_i of the mux)
//   sel     : registered channel index, wired straight to the mux sel port
//   sel_vld : sel holds a valid grant
//   sel_rdy : downstream accepts the current grant
//   gnt     : one-hot accept pulse, gnt[sel] = sel_vld & sel_rdy
// Modports:
//   master : arbiter side (drives sel, sel_vld, gnt)
//   slave  : requester / downstream side (drives req, sel_rdy)
// ---------------------------------------------------------------------------
interface rr_sel_arb_if;
    import rr_sel_pkg::*;

    logic [NCH-1:0]   req;
    logic [SEL_W-1:0] sel;
    logic             sel_vld;
    logic             sel_rdy;
    logic [NCH-1:0]   gnt;

    modport master (
        input  req,
        input  sel_rdy,
        output sel,
        output sel_vld,
        output gnt
    );

    modport slave (
        output req,
        output sel_rdy,
        input  sel,
        input  sel_vld,
        input  gnt
    );

endinterface : rr_sel_arb_if

// File: rtl/rr_pick4.sv
// ---------------------------------------------------------------------------
// rr_pick4 -- combinational rotating priority picker.
// Returns the first set bit of i_req when scanning i_start, i_start+1, ...
// (mod NCH).
//   i_req   : request vector
//   i_start : channel index with the highest priority
//   o_idx   : index of the first requester in scan order (i_start if none)
//   o_any   : at least one request is set
// ---------------------------------------------------------------------------
module rr_pick4
    import rr_sel_pkg::*;
(
    input  logic [NCH-1:0]   i_req,
    input  logic [SEL_W-1:0] i_start,
    output logic [SEL_W-1:0] o_idx,
    output logic             o_any
);

    logic w_found;

    // NOTE: every output of a combinational block is given a default before
    // any conditional assignment, so no path leaves a value held (no latch).
    always_comb begin
        o_idx   = i_start;
        o_any   = |i_req;
        w_found = 1'b0;
        for (int k = 0; k < NCH; k++) begin
            // SEL_W-bit addition wraps naturally at NCH.
            if (!w_found && i_req[i_start + SEL_W'(k)]) begin
                o_idx   = i_start + SEL_W'(k);
                w_found = 1'b1;
            end
        end
    end

endmodule : rr_pick4

// File: rtl/rr_sel_arb.sv
// ---------------------------------------------------------------------------
// rr_sel_arb -- round-robin arbiter producing the select of a 4:1 mux.
//
// A grant is loaded into sel one cycle after a request is seen and held
// until the downstream accepts it (sel_vld & sel_rdy).  On acceptance the
// next requester after the accepted channel is loaded without a bubble.
//
// Parameters:
//   BURST_MAX : max consecutive grants to one channel (1..15), only used
//               when ARB_BURST_EN is defined.
// Configuration macro:
//   ARB_BURST_EN : a channel that keeps requesting is regranted up to
//                  BURST_MAX times in a row before rotation.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : rr_sel_arb_if.master (req, sel_rdy in; sel, sel_vld, gnt out)
// ---------------------------------------------------------------------------
module rr_sel_arb
    import rr_sel_pkg::*;
#(
    parameter int BURST_MAX = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    rr_sel_arb_if.master bus
);

    if (BURST_MAX < 1 || BURST_MAX > 15) begin : g_burst_max_chk
        $error("rr_sel_arb: BURST_MAX must be in 1..15");
    end

    state_t           r_state;
    state_t           w_state_nxt;
    logic [SEL_W-1:0] r_sel;
    logic [SEL_W-1:0] w_sel_nxt;
    logic [SEL_W-1:0] r_last;
    logic [SEL_W-1:0] w_last_nxt;
    logic [SEL_W-1:0] w_start;
    logic [SEL_W-1:0] w_pick_idx;
    logic             w_pick_any;
    logic             w_vld;
    logic             w_xfer;

`ifdef ARB_BURST_EN
    localparam logic [3:0] BURST_LIM = 4'(BURST_MAX - 1);

    logic [3:0] r_cnt;
    logic [3:0] w_cnt_nxt;
`endif

    assign w_vld  = (r_state == GRANT);
    assign w_xfer = w_vld & bus.sel_rdy;

    // In GRANT the search is only consumed on a transfer, where the
    // accepted channel becomes the new last; start right after it.
    assign w_start = w_vld ? (r_sel + SEL_W'(1)) : (r_last + SEL_W'(1));

    rr_pick4 u_pick (
        .i_req   (bus.req),
        .i_start (w_start),
        .o_idx   (w_pick_idx),
        .o_any   (w_pick_any)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel;
        w_last_nxt  = r_last;
`ifdef ARB_BURST_EN
        w_cnt_nxt   = r_cnt;
`endif
        unique case (r_state)
            IDLE: begin
                if (w_pick_any) begin
                    w_sel_nxt   = w_pick_idx;
                    w_state_nxt = GRANT;
                end
            end
            GRANT: begin
                if (w_xfer) begin
                    w_last_nxt = r_sel;
`ifdef ARB_BURST_EN
                    if (bus.req[r_sel] && (r_cnt < BURST_LIM)) begin
                        w_cnt_nxt = r_cnt + 4'd1;
                    end else if (w_pick_any) begin
                        w_sel_nxt = w_pick_idx;
                        w_cnt_nxt = 4'd0;
                    end else begin
                        w_state_nxt = IDLE;
                        w_cnt_nxt   = 4'd0;
                    end
`else
                    if (w_pick_any) begin
                        w_sel_nxt = w_pick_idx;
                    end else begin
                        w_state_nxt = IDLE;
                    end
`endif
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state is updated with non-blocking assignments so all
    // registers sample their next values from the same pre-edge snapshot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_sel   <= '0;
            r_last  <= SEL_W'(NCH - 1);   // first search after reset starts at 0
        end else begin
            r_state <= w_state_nxt;
            r_sel   <= w_sel_nxt;
            r_last  <= w_last_nxt;
        end
    end

`ifdef ARB_BURST_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= 4'd0;
        end else begin
            r_cnt <= w_cnt_nxt;
        end
    end
`endif

    assign bus.sel     = r_sel;
    assign bus.sel_vld = w_vld;
    assign bus.gnt     = w_xfer ? (NCH'(1) << r_sel) : '0;

endmodule : rr_sel_arb
